// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store bus controller: op_size encodings,
// FSM state encodings, the default bus timeout and small lane helpers.
package mem_access_ctrl_pkg;

   localparam int TIMEOUT_DEF = 15;

   localparam logic [1:0] SZ_BYTE     = 2'b00;
   localparam logic [1:0] SZ_HALF     = 2'b01;
   localparam logic [1:0] SZ_WORD     = 2'b10;
   localparam logic [1:0] SZ_WORD_ALT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_e;

   // Byte is always aligned; half needs an even address; word (and 11) needs 4-byte alignment.
   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: is_aligned = 1'b1;
         SZ_HALF: is_aligned = ~addr_lo[0];
         default: is_aligned = (addr_lo == 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: byte_en = 4'b0001 << addr_lo;
         SZ_HALF: byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   endfunction

   // Store data is replicated so whichever lanes the byte enables select carry it.
   function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SZ_BYTE: replicate = {4{wdata[7:0]}};
         SZ_HALF: replicate = {2{wdata[15:0]}};
         default: replicate = wdata;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_ctrl_ld_lane_ext.sv
// Load lane selection and zero/sign extension, steered by the bus byte enables.
module ld_lane_ext (
   input  logic [31:0] bus_rdata,
   input  logic [3:0]  be,
   input  logic        sign,
   output logic [31:0] result
);

   // Pick the enabled lane and extend it; full-word enables pass the data through.
   always_comb begin
      result = bus_rdata;
      case (be)
         4'b0001: result = {{24{sign & bus_rdata[7]}},  bus_rdata[7:0]};
         4'b0010: result = {{24{sign & bus_rdata[15]}}, bus_rdata[15:8]};
         4'b0100: result = {{24{sign & bus_rdata[23]}}, bus_rdata[23:16]};
         4'b1000: result = {{24{sign & bus_rdata[31]}}, bus_rdata[31:24]};
         4'b0011: result = {{16{sign & bus_rdata[15]}}, bus_rdata[15:0]};
         4'b1100: result = {{16{sign & bus_rdata[31]}}, bus_rdata[31:16]};
         default: result = bus_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU load/store to single-beat bus controller with alignment exceptions and
// a bus-wait timeout.
//
// state  | meaning
// IDLE   | waiting for op_valid; misaligned ops flag exc_adel/exc_ades here
// ACCESS | bus_req high, waiting for bus_ack or the wait counter to expire
// RESP   | one-cycle done pulse, rdata already holds the extended load data
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic        op_we,
   input  logic [1:0]  op_size,
   input  logic        op_sign,
   input  logic [31:0] op_addr,
   input  logic [31:0] op_wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic        exc_bus,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        sign_q, sign_d;
   logic        we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        exc_bus_q, exc_bus_d;

   logic        op_aligned;
   logic [3:0]  lane_be;
   logic [31:0] ld_res;

   assign op_aligned = is_aligned(op_size, op_addr[1:0]);
   assign lane_be    = byte_en(size_q, addr_q[1:0]);

   ld_lane_ext u_ld_lane_ext (
      .bus_rdata (bus_rdata),
      .be        (lane_be),
      .sign      (sign_q),
      .result    (ld_res)
   );

   // Next-state, op latching, wait counter and handshake outputs.
   // The timeout moves straight to IDLE with a registered exc_bus pulse, so
   // bus_req drops in the exception cycle; that cycle must not re-accept the
   // still-held op_valid.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      size_d    = size_q;
      sign_d    = sign_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      exc_bus_d = 1'b0;
      bus_req   = 1'b0;
      done      = 1'b0;
      exc_adel  = 1'b0;
      exc_ades  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (op_valid && !exc_bus_q && !rst) begin
               if (op_aligned) begin
                  addr_d  = op_addr;
                  size_d  = op_size;
                  sign_d  = op_sign;
                  we_d    = op_we;
                  wdata_d = op_wdata;
                  cnt_d   = '0;
                  state_d = ST_ACCESS;
               end else if (op_we) begin
                  exc_ades = 1'b1;
               end else begin
                  exc_adel = 1'b1;
               end
            end
         end
         ST_ACCESS: begin
            bus_req = 1'b1;
            if (bus_ack) begin
               if (!we_q) begin
                  rdata_d = ld_res;
               end
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  exc_bus_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end
         ST_RESP: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         size_q    <= SZ_BYTE;
         sign_q    <= 1'b0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         exc_bus_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         sign_q    <= sign_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         exc_bus_q <= exc_bus_d;
      end
   end

   assign exc_bus   = exc_bus_q;
   assign stall     = op_valid & ~rst & ~(done | exc_adel | exc_ades | exc_bus);
   assign rdata     = rdata_q;
   assign bus_we    = we_q & (state_q == ST_ACCESS);
   assign bus_addr  = {addr_q[31:2], 2'b00};
   assign bus_be    = lane_be;
   assign bus_wdata = replicate(size_q, wdata_q);

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL expose parameter TIMEOUT, default 15: bus-wait cycles before a bus error is declared.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 The block SHALL have port op_valid, input, 1: the CPU presents a load/store; held until done or an exception.
REQ-005 The block SHALL have ports op_we (input, 1, store=1), op_size (input, 2, 00 byte/01 half/10 word/11 treated as word) and op_sign (input, 1, sign-extend load).
REQ-006 The block SHALL have ports op_addr (input, 32, byte address) and op_wdata (input, 32, store data, right-justified).
REQ-007 The block SHALL have ports stall (output, 1, freeze pipeline), done (output, 1, one-cycle completion) and rdata (output, 32, extended load data).
REQ-008 The block SHALL have ports exc_adel, exc_ades and exc_bus (outputs, 1 each): misaligned load, misaligned store, bus timeout.
REQ-009 The block SHALL have ports bus_req, bus_we (outputs, 1), bus_addr (output, 32, bits[1:0]=00), bus_be (output, 4) and bus_wdata (output, 32).
REQ-010 The block SHALL have ports bus_ack (input, 1, one-cycle completion) and bus_rdata (input, 32).

Function
REQ-011 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-012 In IDLE with op_valid and an aligned address, the FSM SHALL latch addr, size, sign, we and wdata and enter ACCESS next cycle.
REQ-013 Alignment SHALL be: half needs addr[0]=0; word needs addr[1:0]=00; byte is always aligned.
REQ-014 A misaligned op in IDLE SHALL assert exc_adel (load) or exc_ades (store) combinationally for that cycle, issue no bus request and stay in IDLE.
REQ-015 In ACCESS, bus_req SHALL be 1 and bus_addr/bus_be/bus_we/bus_wdata SHALL be stable until bus_ack.
REQ-016 bus_be SHALL be: byte 1<<addr[1:0]; half 0011 if addr[1]=0, else 1100; word 1111.
REQ-017 bus_wdata SHALL replicate the store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
REQ-018 On bus_ack in ACCESS, the block SHALL register the extended bus_rdata into rdata and enter RESP.
REQ-019 Load extension SHALL select the lane given by bus_be and zero- or sign-extend it per op_sign; word loads pass unchanged.
REQ-020 RESP SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 stall SHALL equal op_valid AND NOT (done OR any exception output).
REQ-022 Minimum load/store latency SHALL be 3 cycles from op_valid to done, given ack in the first ACCESS cycle.
REQ-023 A wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack.
REQ-024 When the counter reaches TIMEOUT, the block SHALL drop bus_req, pulse exc_bus for one cycle and return to IDLE.
REQ-025 bus_ack in the same cycle the counter reaches TIMEOUT SHALL win: normal completion, no exc_bus.
REQ-026 bus_ack outside ACCESS SHALL be ignored.
REQ-027 rdata SHALL hold its last value until the next completed load; stores SHALL leave rdata unchanged.

Reset
REQ-028 While rst=1, the FSM SHALL be IDLE, the counter 0, rdata 0, and stall, done, bus_req and all exc outputs 0.
REQ-029 Reset asserted mid-ACCESS SHALL drop bus_req immediately (asynchronously); the pending op is discarded.

Structure
REQ-030 A shared include file SHALL hold the op_size encodings, FSM state encodings and the TIMEOUT default.
REQ-031 Lane selection and extension SHALL be a combinational sub-module ld_lane_ext (inputs: bus_rdata, be, sign; output: 32-bit result).

Verification
REQ-032 lb with sign=1 at addr 0x1003, ack in cycle 1, bus_rdata 0x80FFFFFF -> bus_be 1000, rdata 0xFFFFFF80, done at cycle 3.
REQ-033 sh at 0x2002, wdata 0x0000ABCD -> bus_be 1100, bus_wdata 0xABCDABCD, bus_we=1, done.
REQ-034 lw at 0x3001 -> exc_adel=1 the same cycle, bus_req never 1.
REQ-035 lw with no ack and TIMEOUT=15 -> bus_req high for 15 cycles, then exc_bus pulse and IDLE.
REQ-036 lhu at 0x4000 with ack after 4 wait cycles and bus_rdata 0x1234F00D -> rdata 0x0000F00D, stall high until done.
REQ-037 rst raised on the 2nd ACCESS cycle -> bus_req falls with no clock edge; after release no done and no exception.
